// File: rtl/trace_serializer.sv
// trace_serializer: slices ready/valid trace words into LSB-first beats on 2**n trace lanes.
module trace_serializer #(
  parameter int WIDTH = 32,
  parameter int MAX_TRACES = 8,
  parameter int CW = ($clog2($clog2(MAX_TRACES) + 1) < 1) ? 1 : $clog2($clog2(MAX_TRACES) + 1)
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [CW-1:0]         NUM_TRACES_I,
  input  logic                  DATA_VALID_I,
  output logic                  DATA_READY_O,
  input  logic [WIDTH-1:0]      DATA_I,
  input  logic                  DATA_TRIG_I,
  input  logic                  TRACE_READY_I,
  output logic                  TRACE_VALID_O,
  output logic [MAX_TRACES-1:0] TRACE_O,
  output logic                  TRIG_O,
  output logic                  BUSY_O
);
  localparam int LN = $clog2(MAX_TRACES);
  localparam int CNTW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0] n_lat, n_in;
  logic [WIDTH-1:0] shreg;
  logic [MAX_TRACES-1:0] lane_mask;
  logic trig_lat, busy, last, accept;
  assign busy = state == SHIFT;
  assign n_in = (NUM_TRACES_I > CW'(LN)) ? CW'(LN) : NUM_TRACES_I;
  assign last = busy && cnt == CNTW'((WIDTH >> n_lat) - 1);
  // ready depends only on registered state and the downstream stall, never on DATA_VALID_I
  assign DATA_READY_O = !busy || (last && TRACE_READY_I);
  assign accept = DATA_VALID_I && DATA_READY_O;
  assign TRACE_VALID_O = busy;
  assign BUSY_O = busy;
  assign TRIG_O = trig_lat && last;
  assign TRACE_O = busy ? (shreg[MAX_TRACES-1:0] & lane_mask) : '0;
  always_comb begin
    for (int j = 0; j < MAX_TRACES; j++) lane_mask[j] = j < (1 << n_lat);
  end
  always_comb begin
    state_d = accept ? SHIFT : (last && TRACE_READY_I) ? IDLE : state;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt <= '0;
      shreg <= '0;
      n_lat <= '0;
      trig_lat <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      shreg <= DATA_I;
      n_lat <= n_in;
      trig_lat <= DATA_TRIG_I;
    end else if (busy && TRACE_READY_I && !last) begin
      cnt <= cnt + CNTW'(1);
      shreg <= shreg >> (1 << n_lat);
    end
  end
endmodule

// File: tb/tb_trace_serializer.sv
// tb_trace_serializer: table vectors, directed corner cases and random traffic against a beat-queue model.
module tb_trace_serializer;
  localparam int WIDTH = 32;
  localparam int MT = 8;
  localparam int LN = 3;
  localparam int CW = 2;
  logic CLK_I = 1'b0;
  logic RST_I, DATA_VALID_I, DATA_READY_O, DATA_TRIG_I, TRACE_READY_I;
  logic TRACE_VALID_O, TRIG_O, BUSY_O;
  logic [CW-1:0] NUM_TRACES_I;
  logic [WIDTH-1:0] DATA_I;
  logic [MT-1:0] TRACE_O;
  logic ro;
  int total = 0;
  int bad = 0;
  typedef struct { logic [7:0] d; logic t; } beat_t;
  beat_t q[$];
  typedef struct {
    logic [CW-1:0] n;
    logic [31:0] w;
    logic t;
    int nb;
    logic [7:0] b0;
    logic [7:0] bl;
    int trigs;
  } vec_t;
  vec_t tbl[5];
  int ev[12];
  trace_serializer #(.WIDTH(WIDTH), .MAX_TRACES(MT)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .NUM_TRACES_I(NUM_TRACES_I),
    .DATA_VALID_I(DATA_VALID_I), .DATA_READY_O(DATA_READY_O), .DATA_I(DATA_I),
    .DATA_TRIG_I(DATA_TRIG_I), .TRACE_READY_I(TRACE_READY_I), .TRACE_VALID_O(TRACE_VALID_O),
    .TRACE_O(TRACE_O), .TRIG_O(TRIG_O), .BUSY_O(BUSY_O)
  );
  always #5 CLK_I = ~CLK_I;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // One clock: drive inputs, compare against the model, advance the model on the edge.
  task automatic step(input logic r, input logic [CW-1:0] n, input logic v,
                      input logic [WIDTH-1:0] d, input logic t, input logic tr, output logic rdo);
    bit rdy, acc, pop;
    int nc, nb;
    RST_I = r; NUM_TRACES_I = n; DATA_VALID_I = v; DATA_I = d; DATA_TRIG_I = t; TRACE_READY_I = tr;
    #1;
    rdy = q.size() == 0 || (q.size() == 1 && tr);
    chk("valid", TRACE_VALID_O, q.size() != 0);
    chk("busy", BUSY_O, q.size() != 0);
    chk("trace", TRACE_O, q.size() != 0 ? q[0].d : 0);
    chk("trig", TRIG_O, q.size() != 0 ? q[0].t : 0);
    if (!r) chk("ready", DATA_READY_O, rdy);
    rdo = DATA_READY_O;
    acc = v && rdy;
    pop = q.size() != 0 && tr;
    @(posedge CLK_I);
    if (r) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        nc = (n > LN) ? LN : n;
        nb = WIDTH >> nc;
        for (int k = 0; k < nb; k++)
          q.push_back('{d: 8'((d >> (k << nc)) & ((1 << (1 << nc)) - 1)), t: t && k == nb - 1});
      end
    end
    #1;
  endtask
  task automatic drain(input logic [CW-1:0] n, output int nb, output logic [7:0] b0,
                       output logic [7:0] bl, output int trigs);
    logic r;
    nb = 0; trigs = 0; b0 = '0; bl = '0;
    while (TRACE_VALID_O === 1'b1 && nb < 64) begin
      if (nb == 0) b0 = TRACE_O;
      bl = TRACE_O;
      trigs += int'(TRIG_O);
      nb++;
      step(1'b0, n, 1'b0, '0, 1'b0, 1'b1, r);
    end
  endtask
  initial begin
    int nb, trigs;
    logic [7:0] b0, bl;
    tbl[0] = '{2'd0, 32'h0000_00A5, 1'b0, 32, 8'h01, 8'h00, 0};
    tbl[1] = '{2'd1, 32'hC000_0002, 1'b1, 16, 8'h02, 8'h03, 1};
    tbl[2] = '{2'd2, 32'h8000_0004, 1'b0, 8, 8'h04, 8'h08, 0};
    tbl[3] = '{2'd3, 32'h1234_5678, 1'b1, 4, 8'h78, 8'h12, 1};
    tbl[4] = '{2'd3, 32'hDEAD_BEEF, 1'b0, 4, 8'hEF, 8'hDE, 0};
    ev = '{1, 2, 2, 2, 2, 3, 4, 0, 0, 0, 0, 0};
    RST_I = 1'b1; NUM_TRACES_I = '0; DATA_VALID_I = 1'b0; DATA_I = '0; DATA_TRIG_I = 1'b0;
    TRACE_READY_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    chk("rst_valid", TRACE_VALID_O, 0);
    chk("rst_trace", TRACE_O, 0);
    chk("rst_trig", TRIG_O, 0);
    chk("rst_busy", BUSY_O, 0);
    RST_I = 1'b0;
    #1;
    chk("rst_ready", DATA_READY_O, 1);
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].n, 1'b1, tbl[i].w, tbl[i].t, 1'b1, ro);
      drain(tbl[i].n, nb, b0, bl, trigs);
      chk("tbl_beats", nb, tbl[i].nb);
      chk("tbl_first", b0, tbl[i].b0);
      chk("tbl_last", bl, tbl[i].bl);
      chk("tbl_trigs", trigs, tbl[i].trigs);
    end
    step(1'b0, 2'd0, 1'b1, 32'h0000_00A5, 1'b0, 1'b1, ro);
    for (int k = 0; k < 32; k++) begin
      chk("ser_lane", TRACE_O, (32'hA5 >> k) & 1);
      chk("ser_ready", DATA_READY_O, k == 31);
      step(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1, ro);
    end
    chk("ser_end", TRACE_VALID_O, 0);
    step(1'b0, 2'd3, 1'b1, 32'h0302_0100, 1'b0, 1'b1, ro);
    for (int k = 0; k < 8; k++) begin
      chk("b2b_valid", TRACE_VALID_O, 1);
      chk("b2b_beat", TRACE_O, k);
      step(1'b0, 2'd3, k <= 3, 32'h0706_0504, 1'b0, 1'b1, ro);
    end
    chk("b2b_end", TRACE_VALID_O, 0);
    step(1'b0, 2'd2, 1'b1, 32'h0000_4321, 1'b0, 1'b1, ro);
    for (int i = 0; i < 12; i++) begin
      chk("stall_beat", TRACE_O, ev[i]);
      step(1'b0, 2'd2, 1'b0, '0, 1'b0, !(i >= 1 && i <= 3), ro);
      if (i >= 1 && i <= 3) chk("stall_ready", ro, 0);
    end
    chk("stall_end", TRACE_VALID_O, 0);
    step(1'b0, 2'd3, 1'b1, 32'hAABB_CCDD, 1'b1, 1'b1, ro);
    for (int k = 0; k < 4; k++) begin
      chk("trig_w1", TRIG_O, k == 3);
      step(1'b0, 2'd3, k == 3, 32'h1122_3344, 1'b0, 1'b1, ro);
    end
    for (int k = 0; k < 4; k++) begin
      chk("trig_w2", TRIG_O, 0);
      step(1'b0, 2'd3, 1'b0, '0, 1'b0, 1'b1, ro);
    end
    step(1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, ro);
    step(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1, ro);
    step(1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b1, ro);
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, 1'b1, ro);
    RST_I = 1'b0;
    #1;
    chk("mid_rst_valid", TRACE_VALID_O, 0);
    chk("mid_rst_trace", TRACE_O, 0);
    chk("mid_rst_busy", BUSY_O, 0);
    chk("mid_rst_ready", DATA_READY_O, 1);
    step(1'b0, 2'd0, 1'b1, 32'h0000_0001, 1'b0, 1'b1, ro);
    chk("mid_rst_b0", TRACE_O, 1);
    drain(2'd0, nb, b0, bl, trigs);
    chk("mid_rst_beats", nb, 32);
    step(1'b0, 2'd3, 1'b1, 32'h1122_3344, 1'b0, 1'b1, ro);
    drain(2'd0, nb, b0, bl, trigs);
    chk("cfg_beats", nb, 4);
    chk("cfg_last", bl, 8'h11);
    step(1'b0, CW'(7), 1'b1, 32'h5566_7788, 1'b0, 1'b1, ro);
    drain(CW'(7), nb, b0, bl, trigs);
    chk("clamp_beats", nb, 4);
    chk("clamp_first", b0, 8'h88);
    for (int c = 0; c < 3000; c++)
      step($urandom_range(99) == 0, CW'($urandom_range(3)), 1'($urandom_range(1)), $urandom,
           1'($urandom_range(1)), $urandom_range(3) != 0, ro);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
